// File: rtl/shift_pkg.sv
// Shared constants for the iterative ALU shifter: FSM encoding, op encoding and default sizes.
package shift_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_SHAMT_W = 5;
  localparam int unsigned DEF_STEP    = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic OP_SLL = 1'b0;
  localparam logic OP_SRA = 1'b1;

endpackage

// File: rtl/shift_left_iter_if.sv
// Operand-issue / writeback handshake bundle for the iterative shifter.
interface shift_left_iter_if
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic               in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shift_step.sv
// Combinational single-stage shifter: shifts data by k (0..STEP) left, or arithmetic right for SRA.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned STEP  = DEF_STEP
) (
  input  logic [WIDTH-1:0]           data,
  input  logic [$clog2(STEP+1)-1:0]  k,
  input  logic                       op,
  output logic [WIDTH-1:0]           shifted_c
);

  always_comb begin
    shifted_c = data << k;
    if (op == OP_SRA) begin
      shifted_c = $unsigned($signed(data) >>> k);
    end
  end

endmodule

// File: rtl/shift_left_iter.sv
// Multi-cycle iterative shifter (SLL, at most STEP bits per clock) with valid/ready on both sides.
// Optional SHIFT_SRA_EN: in_op = 1 selects arithmetic right shift with identical latency.
module shift_left_iter
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned SHAMT_W = DEF_SHAMT_W,
  parameter int unsigned STEP    = DEF_STEP
) (
  input logic              clock,
  input logic              reset_n,
  shift_left_iter_if.slave bus
);

  localparam int unsigned K_W = $clog2(STEP + 1);

  logic [1:0]         state;
  logic [1:0]         stateNext;
  logic [WIDTH-1:0]   dataQ;
  logic [WIDTH-1:0]   dataNext;
  logic [WIDTH-1:0]   stepOut;
  logic [SHAMT_W-1:0] remQ;
  logic [SHAMT_W-1:0] remNext;
  logic [K_W-1:0]     stepK;
  logic               inReadyQ;
  logic               outValidQ;
  logic               accept;
  logic               opCur;

  assign accept = inReadyQ && bus.in_valid;

  // Per-cycle shift amount: min(rem, STEP)
  always_comb begin
    stepK = K_W'(STEP);
    if (remQ < SHAMT_W'(STEP)) begin
      stepK = K_W'(remQ);
    end
  end

`ifdef SHIFT_SRA_EN
  logic opQ;
  logic opNext;

  always_comb begin
    opNext = opQ;
    if ((state == IDLE) && accept) begin
      opNext = bus.in_op;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      opQ <= OP_SLL;
    end else begin
      opQ <= opNext;
    end
  end

  assign opCur = opQ;
`else
  // Op port is present for interface compatibility but every operation is SLL.
  logic unusedOp;
  assign unusedOp = bus.in_op;
  assign opCur    = OP_SLL;
`endif

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data      (dataQ),
    .k         (stepK),
    .op        (opCur),
    .shifted_c (stepOut)
  );

  // Next-state and datapath update
  always_comb begin
    stateNext = state;
    dataNext  = dataQ;
    remNext   = remQ;
    case (state)
      IDLE: begin
        if (accept) begin
          dataNext  = bus.in_data;
          remNext   = bus.in_shamt;
          stateNext = (bus.in_shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        dataNext = stepOut;
        remNext  = remQ - SHAMT_W'(stepK);
        if (remNext == '0) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      dataQ     <= '0;
      remQ      <= '0;
      inReadyQ  <= 1'b1;
      outValidQ <= 1'b0;
    end else begin
      state     <= stateNext;
      dataQ     <= dataNext;
      remQ      <= remNext;
      inReadyQ  <= (stateNext == IDLE);
      outValidQ <= (stateNext == DONE);
    end
  end

  assign bus.in_ready  = inReadyQ;
  assign bus.out_valid = outValidQ;
  assign bus.out_data  = dataQ;

endmodule
